mp64_uart_dbg: RTL and testbench
================================

MP64_UART_DBG -- requirements
Module: mp64_uart_dbg

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1_000_000: the maximum number of idle cycles allowed between bytes of one command before that command is abandoned.
REQ-002 SHALL have ports clk (input, 1), the single clock, and rst_n (input, 1), the reset; reset is asynchronous and active-low.
REQ-003 SHALL have port enable (input, 1); while low, no new UART poll is started.
REQ-004 SHALL have port u_req (output, 1): single-cycle request strobe to the UART register block.
REQ-005 SHALL have ports u_addr (output, 4), u_wdata (output, 8) and u_wen (output, 1): the UART byte offset, write data and write enable.
REQ-006 SHALL have ports u_rdata (input, 8) and u_ack (input, 1): UART read data, valid in the cycle u_ack is high.
REQ-007 SHALL have port m_req (output, 1): request to the memory bus, held high until m_ack.
REQ-008 SHALL have ports m_addr (output, 32), m_wdata (output, 8) and m_wen (output, 1): the memory byte address, write data and write enable.
REQ-009 SHALL have ports m_rdata (input, 8) and m_ack (input, 1): memory read data, valid in the cycle m_ack is high.
REQ-010 SHALL have port busy (output, 1): high whenever the state is not POLL_ST.
REQ-011 SHALL have port timeout (output, 1): a one-cycle pulse when a command is abandoned.

Function
REQ-012 UART offsets SHALL be the UART_TX, UART_RX and UART_STATUS constants from mp64_pkg.vh; STATUS bit0 = tx_ready and bit1 = rx_avail.
REQ-013 UART access rules:
- u_req SHALL be high for exactly one cycle per access.
- u_addr, u_wen and u_wdata SHALL be valid in that cycle.
- u_req SHALL NOT be raised again until u_ack is received, because each u_req cycle on UART_RX pops the FIFO.
REQ-014 Memory access rules:
- m_req SHALL be held with m_addr, m_wen and m_wdata stable until the cycle m_ack is high.
- m_req SHALL drop in the cycle after m_ack.
- m_rdata SHALL be captured in the m_ack cycle.
REQ-015 Protocol:
- 'W' (0x57), then address A3..A0 (big-endian), then data D: write D to address A, then send 0x4B ('K').
- 'R' (0x52), then A3..A0: read address A, then send the byte read.
- Any other opcode: send 0x3F ('?') with no memory access.
REQ-016 States SHALL be: POLL_ST, WAIT_ST, RD_RX, WAIT_RX, DECODE, MEM, TXPOLL, WAIT_TXST, TX_WR, WAIT_TX.
REQ-017 POLL_ST: if enable is high, issue a STATUS read and go to WAIT_ST.
REQ-018 WAIT_ST, on u_ack:
- if rx_avail, go to RD_RX;
- otherwise, if a command is in progress, go to POLL_ST without clearing the partial command;
- otherwise, go to POLL_ST.
REQ-019 RD_RX SHALL issue a UART_RX read; on u_ack in WAIT_RX, it SHALL store the byte, increment the byte count and go to DECODE.
REQ-020 DECODE SHALL go to MEM when the command is complete ('W' with 6 bytes, 'R' with 5 bytes), to TXPOLL for a bad opcode (byte 1), and otherwise to POLL_ST.
REQ-021 MEM SHALL perform the memory access (REQ-014), then go to TXPOLL.
REQ-022 TXPOLL/WAIT_TXST SHALL poll STATUS until tx_ready=1; TX_WR SHALL write the response byte to UART_TX; on u_ack in WAIT_TX the state SHALL be POLL_ST and the byte count SHALL be cleared.
REQ-023 Timeout counter:
- 32-bit counter, reset on every received byte, incremented every cycle while byte count ≠ 0 and state is POLL_ST, WAIT_ST, RD_RX or WAIT_RX.
- On reaching TIMEOUT_CYC: clear byte count, pulse timeout, return to POLL_ST, send no response.
- Not active during MEM or the TX states.
REQ-024 The memory wait and the tx_ready wait SHALL be unbounded, with no timeout.
REQ-025 If enable drops mid-command, the module SHALL still finish any access already issued; the command SHALL resume when enable returns, with the timeout counter still running.
REQ-026 Address bytes SHALL assemble by shift-left-8, so m_addr = {A3,A2,A1,A0}.

Reset
REQ-027 While rst_n is low, the module SHALL be in state POLL_ST with byte count 0 and timeout counter 0.
REQ-028 While rst_n is low, all outputs SHALL be 0: u_req, u_wen, m_req, m_wen, busy, timeout, u_addr, u_wdata, m_addr, m_wdata.
REQ-029 Reset asserted mid-access SHALL abandon the access immediately; the command SHALL NOT be replayed.

Verification
REQ-030 RX bytes 57 00 00 10 20 A5 -> exactly one memory write, m_addr=0x00001020, m_wdata=0xA5; then UART_TX write of 0x4B.
REQ-031 RX bytes 52 00 00 10 20, with memory returning 0x3C after 5 cycles -> m_wen=0, m_req held for 5 cycles, then UART_TX write of 0x3C.
REQ-032 RX byte 0x00 -> UART_TX write of 0x3F and no m_req.
REQ-033 RX bytes 57 12, then silence for TIMEOUT_CYC cycles -> one timeout pulse and no m_req; then 52 00 00 00 04 -> a read at 0x00000004.
REQ-034 tx_ready held at 0 for 50 status polls -> no UART_TX write until tx_ready=1, then exactly one write.
REQ-035 Checker on all tests: u_req is never high on two consecutive cycles, and exactly one UART_RX read is made per received byte.

Source files
------------

// File: rtl/mp64_uart_dbg.sv
// UART debug monitor: polls a UART for 'W'/'R' byte commands and turns them
// into single-byte memory bus accesses, answering over the same UART.
module mp64_uart_dbg #(
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic        u_req,
    output logic [3:0]  u_addr,
    output logic [7:0]  u_wdata,
    output logic        u_wen,
    input  logic [7:0]  u_rdata,
    input  logic        u_ack,
    output logic        m_req,
    output logic [31:0] m_addr,
    output logic [7:0]  m_wdata,
    output logic        m_wen,
    input  logic [7:0]  m_rdata,
    input  logic        m_ack,
    output logic        busy,
    output logic        timeout
);
    // UART register offsets, matching UART_TX/UART_RX/UART_STATUS of mp64_pkg.vh
    localparam logic [3:0] UART_TX     = 4'h0;
    localparam logic [3:0] UART_RX     = 4'h4;
    localparam logic [3:0] UART_STATUS = 4'h8;

    localparam logic [3:0] POLL_ST   = 4'd0;
    localparam logic [3:0] WAIT_ST   = 4'd1;
    localparam logic [3:0] RD_RX     = 4'd2;
    localparam logic [3:0] WAIT_RX   = 4'd3;
    localparam logic [3:0] DECODE    = 4'd4;
    localparam logic [3:0] MEM       = 4'd5;
    localparam logic [3:0] TXPOLL    = 4'd6;
    localparam logic [3:0] WAIT_TXST = 4'd7;
    localparam logic [3:0] TX_WR     = 4'd8;
    localparam logic [3:0] WAIT_TX   = 4'd9;

    localparam logic [7:0] OP_W = 8'h57;
    localparam logic [7:0] OP_R = 8'h52;

    logic [3:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] to_q, to_d;
    logic [7:0]  op_q, op_d, data_q, data_d, resp_q, resp_d;
    logic [31:0] addr_q, addr_d;
    logic        u_req_q, u_req_d, u_wen_q, u_wen_d;
    logic [3:0]  u_addr_q, u_addr_d;
    logic [7:0]  u_wdata_q, u_wdata_d;
    logic        m_req_q, m_req_d, m_wen_q, m_wen_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [7:0]  m_wdata_q, m_wdata_d;
    logic        timeout_q, timeout_d;
    logic        to_hit, to_active, byte_rx;

    assign byte_rx   = (state_q == WAIT_RX) && u_ack;
    assign to_hit    = (cnt_q != 3'd0) && (to_q >= TIMEOUT_CYC);
    assign to_active = (cnt_q != 3'd0) &&
                       (state_q == POLL_ST || state_q == WAIT_ST ||
                        state_q == RD_RX   || state_q == WAIT_RX);

    // The abandon is only taken in POLL_ST so an outstanding UART access
    // (possibly an RX pop) is always allowed to complete first.
    always_comb begin
        to_d = to_q;
        if (cnt_q == 3'd0 || byte_rx || (state_q == POLL_ST && to_hit))
            to_d = '0;
        else if (to_active && to_q != '1)
            to_d = to_q + 32'd1;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        addr_d    = addr_q;
        data_d    = data_q;
        resp_d    = resp_q;
        u_req_d   = 1'b0;
        u_wen_d   = 1'b0;
        u_addr_d  = u_addr_q;
        u_wdata_d = u_wdata_q;
        m_req_d   = m_req_q;
        m_wen_d   = m_wen_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        timeout_d = 1'b0;
        case (state_q)
            POLL_ST: begin
                if (to_hit) begin
                    cnt_d     = 3'd0;
                    timeout_d = 1'b1;
                end else if (enable) begin
                    u_req_d  = 1'b1;
                    u_addr_d = UART_STATUS;
                    state_d  = WAIT_ST;
                end
            end
            WAIT_ST: if (u_ack) state_d = u_rdata[1] ? RD_RX : POLL_ST;
            RD_RX: begin
                u_req_d  = 1'b1;
                u_addr_d = UART_RX;
                state_d  = WAIT_RX;
            end
            WAIT_RX: begin
                if (u_ack) begin
                    case (cnt_q)
                        3'd0:    op_d   = u_rdata;
                        3'd5:    data_d = u_rdata;
                        default: addr_d = {addr_q[23:0], u_rdata};
                    endcase
                    cnt_d   = cnt_q + 3'd1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if ((op_q == OP_W && cnt_q == 3'd6) || (op_q == OP_R && cnt_q == 3'd5)) begin
                    m_req_d   = 1'b1;
                    m_addr_d  = addr_q;
                    m_wen_d   = (op_q == OP_W);
                    m_wdata_d = (op_q == OP_W) ? data_q : 8'h00;
                    state_d   = MEM;
                end else if (cnt_q == 3'd1 && op_q != OP_W && op_q != OP_R) begin
                    resp_d  = 8'h3F;
                    state_d = TXPOLL;
                end else begin
                    state_d = POLL_ST;
                end
            end
            MEM: begin
                if (m_ack) begin
                    m_req_d = 1'b0;
                    m_wen_d = 1'b0;
                    resp_d  = (op_q == OP_W) ? 8'h4B : m_rdata;
                    state_d = TXPOLL;
                end
            end
            TXPOLL: begin
                u_req_d  = 1'b1;
                u_addr_d = UART_STATUS;
                state_d  = WAIT_TXST;
            end
            WAIT_TXST: if (u_ack) state_d = u_rdata[0] ? TX_WR : TXPOLL;
            TX_WR: begin
                u_req_d   = 1'b1;
                u_wen_d   = 1'b1;
                u_addr_d  = UART_TX;
                u_wdata_d = resp_q;
                state_d   = WAIT_TX;
            end
            WAIT_TX: begin
                if (u_ack) begin
                    cnt_d   = 3'd0;
                    state_d = POLL_ST;
                end
            end
            default: state_d = POLL_ST;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= POLL_ST;
            cnt_q     <= '0;
            to_q      <= '0;
            op_q      <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            resp_q    <= '0;
            u_req_q   <= 1'b0;
            u_wen_q   <= 1'b0;
            u_addr_q  <= '0;
            u_wdata_q <= '0;
            m_req_q   <= 1'b0;
            m_wen_q   <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            to_q      <= to_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            resp_q    <= resp_d;
            u_req_q   <= u_req_d;
            u_wen_q   <= u_wen_d;
            u_addr_q  <= u_addr_d;
            u_wdata_q <= u_wdata_d;
            m_req_q   <= m_req_d;
            m_wen_q   <= m_wen_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            timeout_q <= timeout_d;
        end
    end

    assign u_req   = u_req_q;
    assign u_wen   = u_wen_q;
    assign u_addr  = u_addr_q;
    assign u_wdata = u_wdata_q;
    assign m_req   = m_req_q;
    assign m_wen   = m_wen_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign timeout = timeout_q;
    assign busy    = (state_q != POLL_ST);

endmodule

// File: tb/tb_mp64_uart_dbg.sv
// Bench for mp64_uart_dbg: UART and memory responders, a command-level
// protocol model feeding expectation queues, and directed command vectors.
module tb_mp64_uart_dbg;
    localparam int TO = 200;
    localparam logic [3:0] A_TX = 4'h0, A_RX = 4'h4, A_ST = 4'h8;

    logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
    logic        u_req, u_wen, m_req, m_wen, busy, timeout;
    logic [3:0]  u_addr;
    logic [7:0]  u_wdata, m_wdata;
    logic [31:0] m_addr;
    logic [7:0]  u_rdata = 8'h00, m_rdata = 8'h00;
    logic        u_ack = 1'b0, m_ack = 1'b0;

    int tests = 0, fails = 0;

    mp64_uart_dbg #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .u_req(u_req), .u_addr(u_addr), .u_wdata(u_wdata), .u_wen(u_wen),
        .u_rdata(u_rdata), .u_ack(u_ack),
        .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata), .m_wen(m_wen),
        .m_rdata(m_rdata), .m_ack(m_ack),
        .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] a; logic w; logic [7:0] d; } mop_t;

    logic [7:0] rx_q[$];
    logic [7:0] exp_tx[$];
    mop_t       exp_mem[$];
    logic [7:0] mem     [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    logic        tx_rdy = 1'b1;
    int          mem_lat = 3;
    int          rx_reads = 0, pushed = 0, tx_wr_cnt = 0, st_polls = 0;
    int          m_cnt = 0, to_cnt = 0, ureq_cnt = 0, cyc = 0, last_rx_cyc = 0, to_cyc = 0;
    logic [7:0]  last_tx = 8'h00, last_md = 8'h00;
    logic [31:0] last_ma = 32'h0;
    logic        last_mw = 1'b0;
    int          last_hold = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Protocol model: a whole command maps to at most one memory op and one reply byte.
    task automatic send_cmd(input int n, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3,
                            input logic [7:0] b4, input logic [7:0] b5);
        logic [7:0]  b[6];
        logic [31:0] a;
        mop_t        m;
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3; b[4] = b4; b[5] = b5;
        for (int i = 0; i < n; i++) rx_q.push_back(b[i]);
        pushed += n;
        a = {b1, b2, b3, b4};
        if (b0 == 8'h57 && n == 6) begin
            m.a = a; m.w = 1'b1; m.d = b5;
            exp_mem.push_back(m);
            ref_mem[a] = b5;
            exp_tx.push_back(8'h4B);
        end else if (b0 == 8'h52 && n == 5) begin
            m.a = a; m.w = 1'b0; m.d = 8'h00;
            exp_mem.push_back(m);
            exp_tx.push_back(ref_mem.exists(a) ? ref_mem[a] : 8'h00);
        end else if (n >= 1 && b0 != 8'h57 && b0 != 8'h52) begin
            exp_tx.push_back(8'h3F);
        end
    endtask

    // UART responder: ack one cycle after each request; RX pops on request.
    logic       pend = 1'b0, pend_rx = 1'b0, prev_req = 1'b0;
    logic [7:0] pend_d = 8'h00;
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            pend = 1'b0; u_ack = 1'b0; prev_req = 1'b0;
        end else begin
            u_ack = 1'b0;
            if (pend) begin
                u_ack = 1'b1; u_rdata = pend_d; pend = 1'b0;
                if (pend_rx) last_rx_cyc = cyc;
            end
            if (u_req) begin
                ureq_cnt++;
                chk("u_req spacing", {31'b0, prev_req}, 32'd0);
                pend = 1'b1; pend_rx = 1'b0; pend_d = 8'h00;
                case (u_addr)
                    A_ST: begin
                        chk("status wen", {31'b0, u_wen}, 32'd0);
                        pend_d = {6'b0, rx_q.size() != 0, tx_rdy};
                        st_polls++;
                    end
                    A_RX: begin
                        chk("rx wen", {31'b0, u_wen}, 32'd0);
                        chk("rx pop has data", {31'b0, rx_q.size() != 0}, 32'd1);
                        pend_d = (rx_q.size() != 0) ? rx_q.pop_front() : 8'hEE;
                        pend_rx = 1'b1;
                        rx_reads++;
                    end
                    A_TX: begin
                        chk("tx wen", {31'b0, u_wen}, 32'd1);
                        if (exp_tx.size() == 0) begin
                            tests++; fails++;
                            $display("FAIL tx unexpected: got %0h, expected none", u_wdata);
                        end else begin
                            chk("tx byte", {24'b0, u_wdata}, {24'b0, exp_tx.pop_front()});
                        end
                        last_tx = u_wdata;
                        tx_wr_cnt++;
                    end
                    default: chk("u_addr legal", {28'b0, u_addr}, {28'b0, A_ST});
                endcase
            end
            prev_req = u_req;
            if (timeout) begin to_cnt++; to_cyc = cyc; end
        end
    end

    // Memory responder: ack after mem_lat cycles of m_req, check hold and drop.
    logic m_busy = 1'b0, ack_prev = 1'b0;
    int   m_hold = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 1'b0; ack_prev = 1'b0; m_ack = 1'b0; m_hold = 0;
        end else begin
            m_ack = 1'b0;
            if (ack_prev) begin
                chk("m_req drop after ack", {31'b0, m_req}, 32'd0);
                ack_prev = 1'b0;
            end else if (m_req) begin
                if (!m_busy) begin
                    m_busy = 1'b1; m_hold = 0; m_cnt++;
                    last_ma = m_addr; last_mw = m_wen; last_md = m_wdata;
                    if (exp_mem.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL mem unexpected: got addr %0h, expected none", m_addr);
                    end else begin
                        mop_t e;
                        e = exp_mem.pop_front();
                        chk("m_addr", m_addr, e.a);
                        chk("m_wen", {31'b0, m_wen}, {31'b0, e.w});
                        if (e.w) chk("m_wdata", {24'b0, m_wdata}, {24'b0, e.d});
                    end
                end else begin
                    chk("m_addr stable", m_addr, last_ma);
                    chk("m_wen stable", {31'b0, m_wen}, {31'b0, last_mw});
                    chk("m_wdata stable", {24'b0, m_wdata}, {24'b0, last_md});
                end
                m_hold++;
                if (m_hold == mem_lat) begin
                    m_ack = 1'b1;
                    if (m_wen) mem[m_addr] = m_wdata;
                    else m_rdata = mem.exists(m_addr) ? mem[m_addr] : 8'h00;
                    ack_prev = 1'b1; m_busy = 1'b0; last_hold = m_hold;
                end
            end
        end
    end

    task automatic wait_done(input string nm, input int budget);
        int n = 0;
        while ((rx_q.size() != 0 || exp_tx.size() != 0 || exp_mem.size() != 0 || busy)
               && n < budget) begin
            @(negedge clk); n++;
        end
        chk({nm, " completes"}, {31'b0, n < budget}, 32'd1);
        repeat (5) @(negedge clk);
    endtask

    task automatic chk_outs_zero(input string nm);
        chk(nm, {31'b0, |{u_req, u_wen, m_req, m_wen, busy, timeout, u_addr, u_wdata, m_addr, m_wdata}}, 32'd0);
    endtask

    initial begin
        int n, base_m, base_tx, base_p, base_r;
        mem[32'h1020] = 8'h3C; ref_mem[32'h1020] = 8'h3C;
        mem[32'h0004] = 8'h77; ref_mem[32'h0004] = 8'h77;
        repeat (3) @(negedge clk);
        chk_outs_zero("reset outputs");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle no poll when disabled", ureq_cnt, 0);
        enable = 1'b1;

        // read with 5-cycle memory latency
        mem_lat = 5;
        send_cmd(5, 8'h52, 8'h00, 8'h00, 8'h10, 8'h20, 8'h00);
        wait_done("read 1020", 2000);
        chk("read tx 3C", {24'b0, last_tx}, 32'h3C);
        chk("read m_req held", last_hold, 5);
        chk("read m_wen", {31'b0, last_mw}, 32'd0);
        chk("read m_addr", last_ma, 32'h0000_1020);

        // write
        mem_lat = 3;
        send_cmd(6, 8'h57, 8'h00, 8'h00, 8'h10, 8'h20, 8'hA5);
        wait_done("write 1020", 2000);
        chk("write one access", m_cnt, 2);
        chk("write m_addr", last_ma, 32'h0000_1020);
        chk("write m_wdata", {24'b0, last_md}, 32'hA5);
        chk("write m_wen", {31'b0, last_mw}, 32'd1);
        chk("write tx K", {24'b0, last_tx}, 32'h4B);

        send_cmd(5, 8'h52, 8'h00, 8'h00, 8'h10, 8'h20, 8'h00);
        wait_done("readback", 2000);
        chk("readback tx A5", {24'b0, last_tx}, 32'hA5);

        // bad opcode
        base_m = m_cnt;
        send_cmd(1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        wait_done("bad op", 2000);
        chk("bad op tx ?", {24'b0, last_tx}, 32'h3F);
        chk("bad op no m_req", m_cnt, base_m);

        // partial command then silence
        base_tx = tx_wr_cnt;
        send_cmd(2, 8'h57, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00);
        n = 0;
        while (to_cnt == 0 && n < 3 * TO) begin @(negedge clk); n++; end
        chk("timeout pulse seen", to_cnt, 1);
        chk("timeout timing", {31'b0, (to_cyc - last_rx_cyc >= TO) && (to_cyc - last_rx_cyc <= TO + 10)}, 32'd1);
        repeat (TO + 20) @(negedge clk);
        chk("single timeout pulse", to_cnt, 1);
        chk("timeout no m_req", m_cnt, base_m);
        chk("timeout no response", tx_wr_cnt, base_tx);
        send_cmd(5, 8'h52, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00);
        wait_done("read after timeout", 2000);
        chk("post-timeout m_addr", last_ma, 32'h0000_0004);
        chk("post-timeout tx", {24'b0, last_tx}, 32'h77);

        // tx_ready held low
        tx_rdy = 1'b0; base_tx = tx_wr_cnt; base_p = st_polls;
        send_cmd(1, 8'h21, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        n = 0;
        while (st_polls - base_p < 52 && n < 2000) begin @(negedge clk); n++; end
        chk("50 tx polls reached", {31'b0, n < 2000}, 32'd1);
        chk("no tx while not ready", tx_wr_cnt, base_tx);
        tx_rdy = 1'b1;
        wait_done("tx after ready", 2000);
        chk("exactly one tx", tx_wr_cnt, base_tx + 1);

        // enable dropped mid-command
        base_r = rx_reads;
        send_cmd(5, 8'h52, 8'h00, 8'h00, 8'h10, 8'h20, 8'h00);
        n = 0;
        while (rx_reads - base_r < 2 && n < 500) begin @(negedge clk); n++; end
        enable = 1'b0;
        repeat (6) @(negedge clk);
        base_p = ureq_cnt;
        repeat (20) @(negedge clk);
        chk("no poll while disabled", ureq_cnt, base_p);
        chk("idle while disabled", {31'b0, busy}, 32'd0);
        enable = 1'b1;
        wait_done("resume", 2000);
        chk("resume tx A5", {24'b0, last_tx}, 32'hA5);
        chk("one rx read per byte", rx_reads, pushed);

        // reset during a memory access
        mem_lat = 30;
        send_cmd(5, 8'h52, 8'h00, 8'h00, 8'h10, 8'h20, 8'h00);
        n = 0;
        while (!m_busy && n < 500) begin @(negedge clk); n++; end
        chk("mid access reached", {31'b0, m_busy}, 32'd1);
        base_m = m_cnt; base_tx = tx_wr_cnt;
        rst_n = 1'b0;
        #1;
        chk_outs_zero("async reset outputs");
        rx_q.delete(); exp_tx.delete(); exp_mem.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("no replay after reset", m_cnt, base_m);
        chk("no tx after reset", tx_wr_cnt, base_tx);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        fails++;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
